// File: rtl/alu_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// Latency: MT* writes HI/LO at the accept edge; MUL/DIV raise o_done NB_DATA+1 cycles after accept.
// Backpressure: o_ready only in IDLE; requests seen while busy are dropped, so upstream stalls on o_busy.
module alu_muldiv_unit #(
   parameter int NB_DATA  = 32,
   parameter int NB_FUNCT = 6,
   parameter int NB_COUNT = 6
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   input  logic [NB_FUNCT-1:0] i_funct,
   input  logic [NB_DATA-1:0]  i_op_a,
   input  logic [NB_DATA-1:0]  i_op_b,
   input  logic                i_abort,
   output logic                o_ready,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_div_zero,
   output logic [NB_DATA-1:0]  o_hi,
   output logic [NB_DATA-1:0]  o_lo,
   output logic [NB_DATA-1:0]  o_mf_result
);

   localparam logic [NB_FUNCT-1:0] LP_MFHI  = NB_FUNCT'(6'b010000);
   localparam logic [NB_FUNCT-1:0] LP_MTHI  = NB_FUNCT'(6'b010001);
   localparam logic [NB_FUNCT-1:0] LP_MFLO  = NB_FUNCT'(6'b010010);
   localparam logic [NB_FUNCT-1:0] LP_MTLO  = NB_FUNCT'(6'b010011);
   localparam logic [NB_FUNCT-1:0] LP_MULT  = NB_FUNCT'(6'b011000);
   localparam logic [NB_FUNCT-1:0] LP_MULTU = NB_FUNCT'(6'b011001);
   localparam logic [NB_FUNCT-1:0] LP_DIV   = NB_FUNCT'(6'b011010);
   localparam logic [NB_FUNCT-1:0] LP_DIVU  = NB_FUNCT'(6'b011011);
   localparam logic [NB_COUNT-1:0] LP_ITER  = NB_COUNT'(NB_DATA);
   localparam logic [NB_COUNT-1:0] LP_ONE   = NB_COUNT'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;

   // r_acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
   logic [2*NB_DATA-1:0]   r_acc;
   logic [NB_DATA-1:0]     r_opnd;      // |multiplicand| or |divisor|
   logic [NB_COUNT-1:0]    r_count;
   logic                   r_neg_a;     // dividend sign: drives remainder sign
   logic                   r_neg_q;     // result sign for product / quotient
   logic                   r_is_div;
   logic                   r_div_zero;
   logic [NB_DATA-1:0]     r_hi;
   logic [NB_DATA-1:0]     r_lo;

   // request decode
   logic                   w_is_mthi;
   logic                   w_is_mtlo;
   logic                   w_is_mul;
   logic                   w_is_div;
   logic                   w_is_signed;
   logic                   w_accept;
   logic                   w_neg_a;
   logic                   w_neg_b;
   logic [NB_DATA-1:0]     w_abs_a;
   logic [NB_DATA-1:0]     w_abs_b;

   // iteration datapath
   logic [NB_DATA:0]       w_mul_sum;
   logic [2*NB_DATA-1:0]   w_mul_next;
   logic [NB_DATA:0]       w_div_trial;
   logic [NB_DATA:0]       w_div_diff;
   logic [2*NB_DATA-1:0]   w_div_next;

   // sign fix-up
   logic [2*NB_DATA-1:0]   w_mul_res;
   logic [NB_DATA-1:0]     w_quo;
   logic [NB_DATA-1:0]     w_rem;
   logic [NB_DATA-1:0]     w_hi_res;
   logic [NB_DATA-1:0]     w_lo_res;

   assign w_is_mthi   = (i_funct == LP_MTHI);
   assign w_is_mtlo   = (i_funct == LP_MTLO);
   assign w_is_mul    = (i_funct == LP_MULT) || (i_funct == LP_MULTU);
   assign w_is_div    = (i_funct == LP_DIV)  || (i_funct == LP_DIVU);
   assign w_is_signed = (i_funct == LP_MULT) || (i_funct == LP_DIV);
   // abort takes priority over a same-cycle request
   assign w_accept    = (r_state == ST_IDLE) && i_valid && !i_abort;

   // magnitudes; -MIN_INT wraps to MIN_INT, which is the correct unsigned magnitude
   assign w_neg_a = w_is_signed && i_op_a[NB_DATA-1];
   assign w_neg_b = w_is_signed && i_op_b[NB_DATA-1];
   assign w_abs_a = w_neg_a ? -i_op_a : i_op_a;
   assign w_abs_b = w_neg_b ? -i_op_b : i_op_b;

   // shift-add: add multiplicand on multiplier LSB, then shift the whole accumulator right
   assign w_mul_sum  = {1'b0, r_acc[2*NB_DATA-1:NB_DATA]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[NB_DATA-1:1]};

   // restoring divide: shift next dividend bit into remainder, subtract if it fits.
   // A zero divisor yields a garbage quotient, which is replaced in fix-up; the
   // remainder still ends up equal to the dividend magnitude.
   assign w_div_trial = {r_acc[2*NB_DATA-1:NB_DATA], r_acc[NB_DATA-1]};
   assign w_div_diff  = w_div_trial - {1'b0, r_opnd};
   assign w_div_next  = w_div_diff[NB_DATA]
                      ? {w_div_trial[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b0}
                      : {w_div_diff[NB_DATA-1:0],  r_acc[NB_DATA-2:0], 1'b1};

   assign w_mul_res = r_neg_q ? -r_acc : r_acc;
   assign w_quo     = r_acc[NB_DATA-1:0];
   assign w_rem     = r_acc[2*NB_DATA-1:NB_DATA];
   assign w_hi_res  = r_is_div ? (r_neg_a ? -w_rem : w_rem) : w_mul_res[2*NB_DATA-1:NB_DATA];
   assign w_lo_res  = r_is_div ? (r_div_zero ? '1 : (r_neg_q ? -w_quo : w_quo))
                               : w_mul_res[NB_DATA-1:0];

   assign o_hi = r_hi;
   assign o_lo = r_lo;

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   // next-state and handshake/status outputs
   always_comb begin
      w_state_next = r_state;
      o_ready      = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      o_div_zero   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_ready = 1'b1;
            if (w_accept && w_is_mul)      w_state_next = ST_MUL;
            else if (w_accept && w_is_div) w_state_next = ST_DIV;
         end
         ST_MUL, ST_DIV: begin
            o_busy = 1'b1;
            if (i_abort)                 w_state_next = ST_IDLE;
            else if (r_count == LP_ONE)  w_state_next = ST_DONE;
         end
         ST_DONE: begin
            o_busy       = 1'b1;
            w_state_next = ST_IDLE;
            if (!i_abort) begin
               o_done     = 1'b1;
               o_div_zero = r_div_zero;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // operand capture, iteration, and HI/LO commit
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc      <= '0;
         r_opnd     <= '0;
         r_count    <= '0;
         r_neg_a    <= 1'b0;
         r_neg_q    <= 1'b0;
         r_is_div   <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_is_mthi) r_hi <= i_op_a;
                  if (w_is_mtlo) r_lo <= i_op_a;
                  if (w_is_mul || w_is_div) begin
                     r_acc      <= {{NB_DATA{1'b0}}, (w_is_mul ? w_abs_b : w_abs_a)};
                     r_opnd     <= w_is_mul ? w_abs_a : w_abs_b;
                     r_count    <= LP_ITER;
                     r_neg_a    <= w_neg_a;
                     r_neg_q    <= w_neg_a ^ w_neg_b;
                     r_is_div   <= w_is_div;
                     r_div_zero <= w_is_div && (i_op_b == '0);
                  end
               end
            end
            ST_MUL: begin
               if (i_abort) r_count <= '0;
               else begin
                  r_acc   <= w_mul_next;
                  r_count <= r_count - LP_ONE;
               end
            end
            ST_DIV: begin
               if (i_abort) r_count <= '0;
               else begin
                  r_acc   <= w_div_next;
                  r_count <= r_count - LP_ONE;
               end
            end
            ST_DONE: begin
               if (!i_abort) begin
                  r_hi <= w_hi_res;
                  r_lo <= w_lo_res;
               end
            end
            default: ;
         endcase
      end
   end

   // move-from-HI/LO read port, unaffected by busy
   always_comb begin
      o_mf_result = '0;
      if (i_funct == LP_MFHI)      o_mf_result = r_hi;
      else if (i_funct == LP_MFLO) o_mf_result = r_lo;
   end

endmodule
